fetch_stage: RTL and testbench

Program-counter register and instruction-fetch sequencer for the RISC-V core. Holds the architectural PC, drives it to the next-PC logic, loads the computed next PC when decode consumes the current instruction, and runs a request/grant/response handshake with instruction memory. The fetched instruction and its PC are registered and presented to decode under a valid/ready handshake.

---
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response
// channel plus the valid/ready channel toward decode.
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register and single-outstanding fetch sequencer.
// FETCH_ALIGN_CHECK_EN adds an ERR state and the fetch_misaligned output.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_stage_if.master    bus,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] next_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic             fetch_misaligned,
`endif
  output logic [WIDTH-1:0] instr_count
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HOLD, ERR
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, HOLD
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 1'b1;
          state_d = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) state_d = ERR;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ERR: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from flops; no input reaches an output.
  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = {pc_q[WIDTH-1:2], 2'b00};
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign pc              = pc_q;
  assign instr_count     = cnt_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_misaligned = (state_q == ERR);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: responses queued at rvalid,
// popped and compared at the decode handshake.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] instr_count;
  logic [31:0] step = 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_stage_if #(.WIDTH(32)) bus ();

  fetch_stage #(
    .WIDTH(32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .pc(pc),
    .next_pc(next_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign next_pc = pc + step;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          t0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] model_cnt = '0;
  logic [63:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic fetch_one(input int gd, input int rd, input int bd,
                           input logic [31:0] st, input logic spur);
    int          n;
    logic [31:0] w;
    logic [63:0] e;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_cyc = cyc;
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    chk("req_addr", bus.imem_addr, model_pc & ~32'h3);
    for (int i = 0; i < gd; i++) begin
      bus.imem_rvalid = spur;
      bus.imem_rdata  = $urandom;
      @(negedge clk);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
      chk("stall_addr", bus.imem_addr, model_pc & ~32'h3);
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("wait_req", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    w = $urandom;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = w;
    sb.push_back({w, model_pc});
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    for (int i = 0; i < bd; i++) begin
      bus.imem_gnt   = spur;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      chk("bp_instr", bus.instr, sb[0][63:32]);
      chk("bp_ipc", bus.instr_pc, sb[0][31:0]);
      chk("bp_pc", pc, model_pc);
      chk("bp_cnt", instr_count, model_cnt);
      chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
    end
    bus.imem_gnt    = 1'b0;
    step            = st;
    bus.instr_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("instr", bus.instr, e[63:32]);
      chk("instr_pc", bus.instr_pc, e[31:0]);
    end
    @(negedge clk);
    bus.instr_ready = 1'b0;
    model_pc  = model_pc + st;
    model_cnt = model_cnt + 1;
    chk("pc_upd", pc, model_pc);
    chk("count", instr_count, model_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_pc  = RST_PC;
    model_cnt = '0;
    sb.delete();
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_cnt", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_cnt", instr_count, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_ipc", bus.instr_pc, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, RST_PC);

    fetch_one(0, 0, 0, 32'd4, 1'b0);
    t0 = req_cyc;
    fetch_one(0, 0, 0, 32'd4, 1'b0);
    chk("b2b_gap", req_cyc - t0, 32'd3);
    t0 = req_cyc;
    fetch_one(0, 0, 0, 32'hFFFF_FFF8, 1'b0);
    chk("b2b_gap", req_cyc - t0, 32'd3);
    chk("b2b_cnt", instr_count, 32'd3);
    chk("branch_pc", pc, 32'h100);

    fetch_one(4, 0, 0, 32'd4, 1'b1);
    fetch_one(0, 2, 5, 32'd4, 1'b1);
    fetch_one(2, 6, 0, 32'd4, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    fetch_one(0, 0, 0, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("err_flag", {31'd0, fetch_misaligned}, 32'd1);
      chk("err_req", {31'd0, bus.imem_req}, 32'd0);
      chk("err_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    do_reset();
    #1;
    chk("err_clear", {31'd0, fetch_misaligned}, 32'd0);
`else
    fetch_one(0, 0, 0, 32'd2, 1'b0);
    fetch_one(0, 0, 0, 32'd2, 1'b0);
    chk("mask_pc", pc, 32'h110);
`endif

    fetch_one(0, 0, 0, 32'd4, 1'b0);
    @(negedge clk);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("mid_wait", {31'd0, bus.imem_req}, 32'd0);
    do_reset();
    @(negedge clk);
    fetch_one(0, 0, 0, 32'd4, 1'b0);
    chk("post_rst_cnt", instr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end
endmodule
